hack_mmio: RTL and testbench

Data-side memory and memory-mapped I/O for the Hack CPU. It sits directly downstream of the CPU's data port and consumes `data_addr`, `wdata` and `we`. It returns `rdata` combinationally in the same cycle, and drives the DE10-Lite seven-segment displays and LEDs. It owns a small data RAM, debounced push-buttons, synchronized switches and a free-running millisecond timer.

---
 rtl/hack_mmio_if.sv | 23 ++
 rtl/hack_mmio.sv | 237 +++++++++++++++++++++++
 tb/tb_hack_mmio.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_mmio_if.sv
// Hack CPU data-port bus: address, write data, write enable and read data.
// The CPU side drives the request. The memory/IO side answers with rdata,
// which is combinational and available in the same cycle as the address.
interface hack_mmio_if;
  logic [14:0] data_addr;
  logic [15:0] wdata;
  logic        we;
  logic [15:0] rdata;

  modport master (
    output data_addr,
    output wdata,
    output we,
    input  rdata
  );

  modport slave (
    input  data_addr,
    input  wdata,
    input  we,
    output rdata
  );
endinterface : hack_mmio_if

// File: rtl/hack_mmio.sv
// Data-side memory and memory-mapped I/O for the Hack CPU on a DE10-Lite.
// The block contains:
//   - a small aliased data RAM,
//   - a hex display register,
//   - an LED register,
//   - synchronized switches,
//   - debounced keys with a sticky press flag,
//   - a free-running millisecond timer.
// Reads are combinational. Writes commit on the rising edge of CPUclk.
module hack_mmio #(
  parameter int RAM_AW          = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 50000
) (
  input  logic        CPUclk,
  input  logic        nrst,
  hack_mmio_if.slave  bus,
  input  logic [9:0]  SW,
  input  logic [1:0]  KEY,
  output logic [7:0]  HEX0,
  output logic [7:0]  HEX1,
  output logic [7:0]  HEX2,
  output logic [7:0]  HEX3,
  output logic [7:0]  HEX4,
  output logic [7:0]  HEX5,
  output logic [9:0]  LEDR
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int RAM_WORDS = 1 << RAM_AW;

  localparam logic [14:0] ADDR_HEXVAL   = 15'h4000;
  localparam logic [14:0] ADDR_LEDREG   = 15'h4001;
  localparam logic [14:0] ADDR_SWITCHES = 15'h4002;
  localparam logic [14:0] ADDR_KEYS     = 15'h4003;
  localparam logic [14:0] ADDR_TIMER    = 15'h4004;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

  // Encodes a hex nibble for an active-low seven-segment digit.
  // The decimal point is held off.
  function automatic logic [7:0] hex7(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      4'hF:    seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [15:0]             ram_q [RAM_WORDS];
  logic [15:0]             hexval_q, hexval_d;
  logic [3:0][7:0]         hex_seg_q, hex_seg_d;
  logic [9:0]              ledreg_q, ledreg_d;
  logic [9:0]              sw_s1_q, sw_sync_q;
  logic [1:0]              key_s1_q, key_s2_q;
  logic [1:0]              key_state_q, key_state_d;
  logic [1:0][CNT_W-1:0]   db_cnt_q, db_cnt_d;
  logic                    press_flag_q, press_flag_d;
  logic [15:0]             timer_q, timer_d;
  logic [PRE_W-1:0]        presc_q, presc_d;

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  logic              sel_ram_s;
  logic              wr_hex_s, wr_led_s, wr_keys_s, wr_timer_s, wr_ram_s;
  logic [1:0]        key_in_s;
  logic [RAM_AW-1:0] ram_idx_s;

  // The RAM occupies the lower half of the space (address bit 14 clear).
  assign sel_ram_s  = ~bus.data_addr[14];
  assign ram_idx_s  = bus.data_addr[RAM_AW-1:0];
  assign wr_ram_s   = bus.we & sel_ram_s;
  assign wr_hex_s   = bus.we & (bus.data_addr == ADDR_HEXVAL);
  assign wr_led_s   = bus.we & (bus.data_addr == ADDR_LEDREG);
  assign wr_keys_s  = bus.we & (bus.data_addr == ADDR_KEYS);
  assign wr_timer_s = bus.we & (bus.data_addr == ADDR_TIMER);

  // Synchronized keys are active-low, so invert them to give 1 = pressed.
  assign key_in_s = ~key_s2_q;

  // Read mux: combinational from the current address and state.
  // Because writes only land at the clock edge, a read in the same cycle
  // as a write to that address still returns the old contents.
  always_comb begin
    bus.rdata = 16'h0000;
    if (sel_ram_s) begin
      bus.rdata = ram_q[ram_idx_s];
    end else begin
      case (bus.data_addr)
        ADDR_HEXVAL:   bus.rdata = hexval_q;
        ADDR_LEDREG:   bus.rdata = {6'b000000, ledreg_q};
        ADDR_SWITCHES: bus.rdata = {6'b000000, sw_sync_q};
        ADDR_KEYS:     bus.rdata = {press_flag_q, 13'b0, key_state_q};
        ADDR_TIMER:    bus.rdata = timer_q;
        default:       bus.rdata = 16'h0000;
      endcase
    end
  end

  // Next-state logic for the registers, debounce, press flag and timer.
  always_comb begin
    hexval_d     = hexval_q;
    ledreg_d     = ledreg_q;
    key_state_d  = key_state_q;
    db_cnt_d     = db_cnt_q;
    press_flag_d = press_flag_q;
    timer_d      = timer_q;
    presc_d      = presc_q;

    if (wr_hex_s) begin
      hexval_d = bus.wdata;
    end else begin
      hexval_d = hexval_q;
    end

    if (wr_led_s) begin
      ledreg_d = bus.wdata[9:0];
    end else begin
      ledreg_d = ledreg_q;
    end

    // Segment patterns are registered alongside HEXVAL.
    // This keeps the display pins glitch-free while adding no extra
    // cycle of latency.
    for (int d = 0; d < 4; d++) begin
      hex_seg_d[d] = hex7(hexval_d[4*d +: 4]);
    end

    // Debounce: the counter runs only while the input disagrees with the
    // accepted state. It resets as soon as the two agree again, so any
    // glitch shorter than the window leaves no trace.
    for (int k = 0; k < 2; k++) begin
      if (key_in_s[k] != key_state_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          key_state_d[k] = key_in_s[k];
          db_cnt_d[k]    = {CNT_W{1'b0}};
        end else begin
          db_cnt_d[k]    = db_cnt_q[k] + CNT_W'(1);
        end
      end else begin
        db_cnt_d[k] = {CNT_W{1'b0}};
      end
    end

    // A new press of KEY[1] takes priority over a clearing write,
    // so that a press is never lost.
    if (~key_state_q[1] & key_state_d[1]) begin
      press_flag_d = 1'b1;
    end else if (wr_keys_s) begin
      press_flag_d = 1'b0;
    end else begin
      press_flag_d = press_flag_q;
    end

    // Timer: a CPU write overrides a tick that falls in the same cycle.
    if (wr_timer_s) begin
      timer_d = bus.wdata;
      presc_d = {PRE_W{1'b0}};
    end else if (presc_q == PRE_LAST) begin
      timer_d = timer_q + 16'h0001;
      presc_d = {PRE_W{1'b0}};
    end else begin
      timer_d = timer_q;
      presc_d = presc_q + PRE_W'(1);
    end
  end

  // Data RAM: synchronous write with no reset.
  // A write is suppressed while reset is held, so a reset aborts it.
  always_ff @(posedge CPUclk) begin
    if (nrst && wr_ram_s) begin
      ram_q[ram_idx_s] <= bus.wdata;
    end
  end

  // Control and status registers, with asynchronous reset.
  always_ff @(posedge CPUclk or negedge nrst) begin
    if (!nrst) begin
      hexval_q     <= 16'h0000;
      hex_seg_q    <= {4{8'hC0}};
      ledreg_q     <= 10'h000;
      sw_s1_q      <= 10'h000;
      sw_sync_q    <= 10'h000;
      key_s1_q     <= 2'b11;
      key_s2_q     <= 2'b11;
      key_state_q  <= 2'b00;
      db_cnt_q     <= '0;
      press_flag_q <= 1'b0;
      timer_q      <= 16'h0000;
      presc_q      <= {PRE_W{1'b0}};
    end else begin
      hexval_q     <= hexval_d;
      hex_seg_q    <= hex_seg_d;
      ledreg_q     <= ledreg_d;
      sw_s1_q      <= SW;
      sw_sync_q    <= sw_s1_q;
      key_s1_q     <= KEY;
      key_s2_q     <= key_s1_q;
      key_state_q  <= key_state_d;
      db_cnt_q     <= db_cnt_d;
      press_flag_q <= press_flag_d;
      timer_q      <= timer_d;
      presc_q      <= presc_d;
    end
  end

  assign HEX0 = hex_seg_q[0];
  assign HEX1 = hex_seg_q[1];
  assign HEX2 = hex_seg_q[2];
  assign HEX3 = hex_seg_q[3];
  assign HEX4 = 8'hFF;
  assign HEX5 = 8'hFF;
  assign LEDR = ledreg_q;

endmodule : hack_mmio

// File: tb/tb_hack_mmio.sv
// Scoreboard bench for hack_mmio.
// Stimulus pushes the expected observation for the current cycle.
// A monitor samples the DUT on the falling edge and compares.
module tb_hack_mmio;

  localparam int K_RD   = 0;
  localparam int K_HEX0 = 1;
  localparam int K_HEX1 = 2;
  localparam int K_HEX2 = 3;
  localparam int K_HEX3 = 4;
  localparam int K_HEX4 = 5;
  localparam int K_HEX5 = 6;
  localparam int K_LEDR = 7;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic       clk;
  logic       nrst;
  logic [9:0] sw;
  logic [1:0] key;
  logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic [9:0] ledr;
  logic       chk;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  hack_mmio_if bus ();

  hack_mmio #(
    .RAM_AW          (8),
    .DEBOUNCE_CYCLES (8),
    .TICK_CYCLES     (4)
  ) dut (
    .CPUclk (clk),
    .nrst   (nrst),
    .bus    (bus),
    .SW     (sw),
    .KEY    (key),
    .HEX0   (hex0),
    .HEX1   (hex1),
    .HEX2   (hex2),
    .HEX3   (hex3),
    .HEX4   (hex4),
    .HEX5   (hex5),
    .LEDR   (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares the DUT against the oldest expectation whenever a
  // check is flagged for the current cycle.
  always @(negedge clk) begin
    if (chk) begin
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL scoreboard_empty: check flagged with no expectation");
      end else begin
        exp_t        e;
        logic [15:0] obs;
        e = sb.pop_front();
        case (e.kind)
          K_RD:    obs = bus.rdata;
          K_HEX0:  obs = {8'h00, hex0};
          K_HEX1:  obs = {8'h00, hex1};
          K_HEX2:  obs = {8'h00, hex2};
          K_HEX3:  obs = {8'h00, hex3};
          K_HEX4:  obs = {8'h00, hex4};
          K_HEX5:  obs = {8'h00, hex5};
          K_LEDR:  obs = {6'h00, ledr};
          default: obs = 16'hxxxx;
        endcase
        n_vec++;
        if (obs !== e.exp) begin
          n_miss++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.exp);
        end
      end
    end
  end

  // One cycle: check something at address a. The task returns 1 time unit
  // after the next rising edge.
  task automatic do_check(input int kind, input logic [14:0] a,
                          input logic [15:0] exp, input string name);
    exp_t e;
    e.kind = kind; e.exp = exp; e.name = name;
    bus.data_addr = a;
    bus.we        = 1'b0;
    sb.push_back(e);
    chk = 1'b1;
    @(posedge clk); #1;
    chk = 1'b0;
  endtask

  // One cycle: write d to address a.
  task automatic do_write(input logic [14:0] a, input logic [15:0] d);
    bus.data_addr = a;
    bus.wdata     = d;
    bus.we        = 1'b1;
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  // One cycle: write d to address a, and check the read-back in that same
  // cycle.
  task automatic do_write_chk(input logic [14:0] a, input logic [15:0] d,
                              input logic [15:0] exp, input string name);
    exp_t e;
    e.kind = K_RD; e.exp = exp; e.name = name;
    bus.data_addr = a;
    bus.wdata     = d;
    bus.we        = 1'b1;
    sb.push_back(e);
    chk = 1'b1;
    @(posedge clk); #1;
    chk    = 1'b0;
    bus.we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Pulse reset for one edge. Reset releases 1 time unit after that edge.
  task automatic reset_dut();
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    chk  = 1'b0;
    sw   = 10'h000;
    key  = 2'b11;
    bus.data_addr = 15'h0000;
    bus.wdata     = 16'h0000;
    bus.we        = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;

    // Reset state.
    do_check(K_RD,   15'h4004, 16'h0000, "rst_timer");
    do_check(K_RD,   15'h4000, 16'h0000, "rst_hexval");
    do_check(K_RD,   15'h4001, 16'h0000, "rst_ledreg");
    do_check(K_RD,   15'h4003, 16'h0000, "rst_keys");
    do_check(K_RD,   15'h4002, 16'h0000, "rst_switches");
    do_check(K_HEX0, 15'h0000, 16'h00C0, "rst_hex0");
    do_check(K_HEX1, 15'h0000, 16'h00C0, "rst_hex1");
    do_check(K_HEX2, 15'h0000, 16'h00C0, "rst_hex2");
    do_check(K_HEX3, 15'h0000, 16'h00C0, "rst_hex3");
    do_check(K_HEX4, 15'h0000, 16'h00FF, "rst_hex4");
    do_check(K_HEX5, 15'h0000, 16'h00FF, "rst_hex5");
    do_check(K_LEDR, 15'h0000, 16'h0000, "rst_ledr");

    // RAM: write, read back, read through an alias, and read during a write.
    do_write(15'h0005, 16'h1234);
    do_check(K_RD, 15'h0005, 16'h1234, "ram_rd");
    do_check(K_RD, 15'h0105, 16'h1234, "ram_alias");
    do_check(K_RD, 15'h3F05, 16'h1234, "ram_alias_top");
    do_write_chk(15'h0005, 16'h5678, 16'h1234, "ram_rd_during_wr");
    do_check(K_RD, 15'h0005, 16'h5678, "ram_rd_after_wr");

    // HEXVAL and LEDREG.
    do_write(15'h4000, 16'hBEEF);
    do_check(K_HEX3, 15'h4000, 16'h0083, "hex3_B");
    do_check(K_HEX2, 15'h4000, 16'h0086, "hex2_E");
    do_check(K_HEX1, 15'h4000, 16'h0086, "hex1_E");
    do_check(K_HEX0, 15'h4000, 16'h008E, "hex0_F");
    do_check(K_RD,   15'h4000, 16'hBEEF, "hexval_rd");
    do_check(K_HEX5, 15'h4000, 16'h00FF, "hex5_blank");
    do_write(15'h4001, 16'hFFFF);
    do_check(K_LEDR, 15'h4001, 16'h03FF, "ledr_3ff");
    do_check(K_RD,   15'h4001, 16'h03FF, "ledreg_rd");

    // Switches: two-flop latency.
    sw = 10'h2A5;
    do_check(K_RD, 15'h4002, 16'h0000, "sw_lat0");
    do_check(K_RD, 15'h4002, 16'h0000, "sw_lat1");
    do_check(K_RD, 15'h4002, 16'h02A5, "sw_lat2");

    // Timer: 12 cycles after reset reads 3.
    reset_dut();
    idle(12);
    do_check(K_RD, 15'h4004, 16'h0003, "timer_12cyc");
    // Load 0xFFFF. It wraps on the fourth following edge.
    do_write(15'h4004, 16'hFFFF);
    idle(3);
    do_check(K_RD, 15'h4004, 16'hFFFF, "timer_pre_wrap");
    do_check(K_RD, 15'h4004, 16'h0000, "timer_wrap");
    // The prescaler is now 1. After two more edges it is at its last
    // count, so the next write coincides with a tick.
    idle(2);
    do_write(15'h4004, 16'h1234);
    do_check(K_RD, 15'h4004, 16'h1234, "timer_wr_vs_tick");

    // Keys: a 5-cycle glitch is ignored.
    key = 2'b01;
    idle(5);
    key = 2'b11;
    idle(10);
    do_check(K_RD, 15'h4003, 16'h0000, "key_glitch");
    // Hold KEY[1] low: the key is accepted on the tenth edge.
    key = 2'b01;
    idle(9);
    do_check(K_RD, 15'h4003, 16'h0000, "key_edge9");
    do_check(K_RD, 15'h4003, 16'h8002, "key_press");
    do_write(15'h4003, 16'h0000);
    do_check(K_RD, 15'h4003, 16'h0002, "key_flag_clr");
    key = 2'b11;
    idle(9);
    do_check(K_RD, 15'h4003, 16'h0002, "key_rel_edge9");
    do_check(K_RD, 15'h4003, 16'h0000, "key_release");

    // Unmapped addresses.
    do_write(15'h5000, 16'hDEAD);
    do_check(K_RD, 15'h5000, 16'h0000, "unmapped_5000");
    do_check(K_RD, 15'h4005, 16'h0000, "unmapped_4005");
    do_check(K_RD, 15'h4000, 16'h0000, "hexval_after_unmapped");

    // Reset during a HEXVAL write.
    do_write(15'h4000, 16'h00A5);
    do_check(K_HEX0, 15'h4000, 16'h0092, "hex0_5");
    bus.data_addr = 15'h4000;
    bus.wdata     = 16'h5555;
    bus.we        = 1'b1;
    nrst          = 1'b0;
    @(posedge clk); #1;
    bus.we = 1'b0;
    nrst   = 1'b1;
    do_check(K_RD,   15'h4000, 16'h0000, "hexval_rst_abort");
    do_check(K_HEX0, 15'h4000, 16'h00C0, "hex0_rst_abort");
    do_check(K_HEX1, 15'h4000, 16'h00C0, "hex1_rst_abort");

    idle(2);
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_left: %0d expectations unconsumed, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_hack_mmio
